// File: rtl/ssp_pkg.sv
// Shared constants and helpers for the SSP receive path.
package ssp_pkg;

  localparam int unsigned SSP_DATA_W_DEFAULT   = 8;
  localparam int unsigned SSP_RX_DEPTH_DEFAULT = 8;

  // {PSEL, PENABLE, PWRITE} during an APB read access phase
  localparam logic [2:0] SSP_APB_RD = 3'b110;

  function automatic int unsigned ssp_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ssp_fifo_ram.sv
// FIFO storage: one synchronous write port, one registered read port.
module ssp_fifo_ram
  import ssp_pkg::*;
#(
  parameter int unsigned DATA_W = SSP_DATA_W_DEFAULT,
  parameter int unsigned DEPTH  = SSP_RX_DEPTH_DEFAULT,
  parameter int unsigned AW     = ssp_clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read register holds its value when no pop occurs
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ssp_rx_fifo_param.sv
// SSP receive FIFO with level/flags, threshold and overrun interrupts.
// Define SSP_RX_TIMEOUT_EN to build the receive-timeout interrupt.
module ssp_rx_fifo_param
  import ssp_pkg::*;
#(
  parameter int unsigned DATA_W    = SSP_DATA_W_DEFAULT,
  parameter int unsigned DEPTH     = SSP_RX_DEPTH_DEFAULT,
  parameter int unsigned RX_THRESH = 4,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic                      PCLK,
  input  logic                      CLEAR,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [DATA_W-1:0]         RxData,
  input  logic                      rx_ready,
  input  logic                      ror_clr,
  output logic [DATA_W-1:0]         PRDATA,
  output logic                      rx_empty,
  output logic                      rx_full,
  output logic [ssp_clog2(DEPTH):0] rx_level,
  output logic                      SSPRXINTR,
  output logic                      SSPRORINTR,
  output logic                      SSPRTINTR
);

  localparam int unsigned AW = ssp_clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [AW:0] ThreshVal = LW'(RX_THRESH);

  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d, level_q, level_d;
  logic        empty_q, full_q, full_d, rxintr_q, ror_q, ror_d;
  logic        rd_access, pop, push, drop;

  assign rd_access = ({PSEL, PENABLE, PWRITE} == SSP_APB_RD);
  assign pop       = rd_access & ~empty_q;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the frame
  assign push      = rx_ready & (~full_q | pop);
  assign drop      = rx_ready & full_q & ~pop;

  always_comb begin
    wptr_d  = wptr_q + {{AW{1'b0}}, push};
    rptr_d  = rptr_q + {{AW{1'b0}}, pop};
    level_d = wptr_d - rptr_d;
    full_d  = (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
    ror_d   = drop | (ror_q & ~ror_clr);
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      rxintr_q <= 1'b0;
      ror_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      level_q  <= level_d;
      empty_q  <= (level_d == '0);
      full_q   <= full_d;
      rxintr_q <= (level_d >= ThreshVal);
      ror_q    <= ror_d;
    end
  end

  ssp_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk_i   (PCLK),
    .clr_i   (CLEAR),
    .we_i    (push),
    .waddr_i (wptr_q[AW-1:0]),
    .wdata_i (RxData),
    .re_i    (pop),
    .raddr_i (rptr_q[AW-1:0]),
    .rdata_o (PRDATA)
  );

  assign rx_empty   = empty_q;
  assign rx_full    = full_q;
  assign rx_level   = level_q;
  assign SSPRXINTR  = rxintr_q;
  assign SSPRORINTR = ror_q;

`ifdef SSP_RX_TIMEOUT_EN
  localparam int unsigned TW = ssp_clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT);

  logic [TW-1:0] idle_q, idle_d;

  // Saturating idle counter; only runs while frames are waiting
  always_comb begin
    idle_d = idle_q;
    if (push || pop || empty_q) begin
      idle_d = '0;
    end else if (idle_q != TimeoutVal) begin
      idle_d = idle_q + TW'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) idle_q <= '0;
    else       idle_q <= idle_d;
  end

  assign SSPRTINTR = ~empty_q & (idle_q == TimeoutVal);
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign SSPRTINTR      = 1'b0;
`endif

endmodule

// File: tb/tb_ssp_rx_fifo_param.sv
// Randomised bench for ssp_rx_fifo_param against a queue-based reference model.
module tb_ssp_rx_fifo_param;

  localparam int unsigned DATA_W    = 8;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned RX_THRESH = 4;
  localparam int unsigned TIMEOUT   = 32;
`ifdef SSP_RX_TIMEOUT_EN
  localparam int RT_ON = 1;
`else
  localparam int RT_ON = 0;
`endif

  logic              PCLK = 1'b0;
  logic              CLEAR = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic              rx_ready = 1'b0, ror_clr = 1'b0;
  logic [DATA_W-1:0] RxData = '0;
  logic [DATA_W-1:0] PRDATA;
  logic              rx_empty, rx_full, SSPRXINTR, SSPRORINTR, SSPRTINTR;
  logic [3:0]        rx_level;

  ssp_rx_fifo_param #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .RX_THRESH (RX_THRESH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .PCLK       (PCLK),
    .CLEAR      (CLEAR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .RxData     (RxData),
    .rx_ready   (rx_ready),
    .ror_clr    (ror_clr),
    .PRDATA     (PRDATA),
    .rx_empty   (rx_empty),
    .rx_full    (rx_full),
    .rx_level   (rx_level),
    .SSPRXINTR  (SSPRXINTR),
    .SSPRORINTR (SSPRORINTR),
    .SSPRTINTR  (SSPRTINTR)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  // Reference model: contents as a queue, plus last popped frame and sticky bits
  logic [7:0] q[$];
  logic [7:0] m_prdata = 8'h00;
  bit         m_ror = 1'b0;
  int         m_idle = 0;
  bit         chk_en = 1'b0;

  bit         lit_en = 1'b0;
  int         lit_prdata, lit_level, lit_ror, lit_rt;

  always @(posedge PCLK) begin : model
    bit do_pop, room, take;
    if (CLEAR) begin
      q.delete();
      m_prdata = 8'h00;
      m_ror    = 1'b0;
      m_idle   = 0;
    end else begin
      do_pop = PSEL && PENABLE && !PWRITE && (q.size() > 0);
      room   = (q.size() < DEPTH) || do_pop;
      take   = rx_ready && room;
      if (do_pop) m_prdata = q.pop_front();
      if (take) q.push_back(RxData);
      if (rx_ready && !room) m_ror = 1'b1;
      else if (ror_clr)      m_ror = 1'b0;
      if (do_pop || take || q.size() == 0) m_idle = 0;
      else if (m_idle < TIMEOUT)            m_idle++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge PCLK) begin : compare
    int exp_rt;
    if (chk_en) begin
      exp_rt = (RT_ON != 0 && q.size() > 0 && m_idle == TIMEOUT) ? 1 : 0;
      check("prdata",  32'(PRDATA),     32'(m_prdata));
      check("level",   32'(rx_level),   32'(q.size()));
      check("empty",   32'(rx_empty),   32'(q.size() == 0));
      check("full",    32'(rx_full),    32'(q.size() == DEPTH));
      check("rxintr",  32'(SSPRXINTR),  32'(q.size() >= RX_THRESH));
      check("rorintr", 32'(SSPRORINTR), 32'(m_ror));
      check("rtintr",  32'(SSPRTINTR),  32'(exp_rt));
    end
    if (lit_en) begin
      check("lit_prdata", 32'(PRDATA),     32'(lit_prdata));
      check("lit_level",  32'(rx_level),   32'(lit_level));
      check("lit_ror",    32'(SSPRORINTR), 32'(lit_ror));
      check("lit_rt",     32'(SSPRTINTR),  32'(lit_rt));
    end
  end

  task automatic cyc(input bit rdy, input logic [7:0] d, input bit rd,
                     input bit clr = 1'b0, input bit rc = 1'b0);
    rx_ready = rdy;
    RxData   = d;
    PSEL     = rd;
    PENABLE  = rd;
    PWRITE   = 1'b0;
    CLEAR    = clr;
    ror_clr  = rc;
    @(posedge PCLK);
    #1;
    rx_ready = 1'b0;
    PSEL     = 1'b0;
    PENABLE  = 1'b0;
    CLEAR    = 1'b0;
    ror_clr  = 1'b0;
  endtask

  task automatic lit(input int p, input int l, input int r, input int t);
    lit_prdata = p;
    lit_level  = l;
    lit_ror    = r;
    lit_rt     = t;
    lit_en     = 1'b1;
    @(negedge PCLK);
    #1;
    lit_en = 1'b0;
  endtask

  initial begin
    #2;
    cyc(0, 8'h00, 0, 1);
    chk_en = 1'b1;
    lit(8'h00, 0, 0, 0);

    // CLEAR mid-burst, with a coincident strobe that must be discarded
    for (int i = 1; i <= 3; i++) cyc(1, 8'(i), 0);
    cyc(1, 8'h04, 0, 1);
    lit(8'h00, 0, 0, 0);
    cyc(1, 8'h11, 0);
    cyc(0, 8'h00, 1);
    lit(8'h11, 0, 0, 0);

    // Fill and drain in order
    for (int i = 0; i < 8; i++) cyc(1, 8'hA0 + 8'(i), 0);
    lit(8'h11, 8, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 8'h00, 1);
      lit(8'hA0 + i, 7 - i, 0, 0);
    end

    // Overrun on full, sticky until ror_clr
    for (int i = 0; i < 8; i++) cyc(1, 8'hA0 + 8'(i), 0);
    cyc(1, 8'hFF, 0);
    lit(8'hA7, 8, 1, 0);
    cyc(0, 8'h00, 1);
    lit(8'hA0, 7, 1, 0);
    cyc(0, 8'h00, 0, 0, 1);
    lit(8'hA0, 7, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1);
    lit(8'hA7, 0, 0, 0);

    // Simultaneous push+pop when full, then when empty
    for (int i = 0; i < 8; i++) cyc(1, 8'hB0 + 8'(i), 0);
    cyc(1, 8'h55, 1);
    lit(8'hB0, 8, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1);
    lit(8'hB7, 1, 0, 0);
    cyc(0, 8'h00, 1);
    lit(8'h55, 0, 0, 0);
    cyc(1, 8'h66, 1);
    lit(8'h55, 1, 0, 0);
    cyc(0, 8'h00, 1);
    lit(8'h66, 0, 0, 0);

    // Pointer wrap with steady level 3
    for (int i = 0; i < 3; i++) cyc(1, 8'hC0 + 8'(i), 0);
    for (int i = 0; i < 20; i++) cyc(1, 8'hC3 + 8'(i), 1);
    lit(8'hD3, 3, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1);
    lit(8'hD6, 0, 0, 0);

    // Receive timeout
    cyc(1, 8'h77, 0);
    for (int i = 0; i < 31; i++) cyc(0, 8'h00, 0);
    lit(8'hD6, 1, 0, 0);
    cyc(0, 8'h00, 0);
    lit(8'hD6, 1, 0, RT_ON);
    for (int i = 0; i < 5; i++) cyc(0, 8'h00, 0);
    lit(8'hD6, 1, 0, RT_ON);
    cyc(0, 8'h00, 1);
    lit(8'h77, 0, 0, 0);

    // Random traffic: push-heavy phase, then pop-heavy phase
    for (int n = 0; n < 3000; n++) begin
      rx_ready = ($urandom_range(0, 99) < ((n < 1500) ? 60 : 15));
      RxData   = 8'($urandom);
      PSEL     = ($urandom_range(0, 99) < 60);
      PENABLE  = ($urandom_range(0, 99) < 70);
      PWRITE   = ($urandom_range(0, 9) == 0);
      ror_clr  = ($urandom_range(0, 29) == 0);
      CLEAR    = ($urandom_range(0, 399) == 0);
      @(posedge PCLK);
      #1;
    end
    rx_ready = 1'b0;
    PSEL     = 1'b0;
    PENABLE  = 1'b0;
    PWRITE   = 1'b0;
    ror_clr  = 1'b0;
    CLEAR    = 1'b0;
    @(negedge PCLK);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
